button_conditioner: RTL and testbench

//  Multi-channel successor to the single-bit edge detector. Per channel: synchronises a raw

---
 rtl/button_pkg.sv | 23 ++
 rtl/button_channel.sv | 136 +++++++++++++
 rtl/button_conditioner.sv | 67 ++++++
 tb/tb_button_conditioner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module      : button_pkg                                                 |
// | Description : Shared types and helpers for the button conditioner:       |
// |               repeat FSM state encoding and counter-width function.      |
// | Revision    : 1.0 - initial multi-channel release                        |
// ----------------------------------------------------------------------------
package button_pkg;

  // Hold-to-repeat state of one channel.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  // Bits needed to hold the larger of two cycle counts without wrapping.
  function automatic int clog2_max(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module      : button_channel                                             |
// | Description : One input channel: synchroniser, debounce counter,         |
// |               registered rise/fall pulses and hold-to-repeat FSM.        |
// | Revision    : 1.0 - initial multi-channel release                        |
// ----------------------------------------------------------------------------
module button_channel
  import button_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   REPEAT_DELAY    = 25000000,
  parameter int   REPEAT_PERIOD   = 5000000,
  parameter logic INIT_LEVEL      = 1'b1,
  parameter logic PRESS_LEVEL     = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_i,
  input  logic repeat_en_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic press_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = clog2_max(REPEAT_DELAY, REPEAT_PERIOD);

  localparam logic [DW-1:0] c_dcnt_max    = DW'(DEBOUNCE_CYCLES);
  localparam logic [RW-1:0] c_delay_last  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] c_period_last = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] c_rcnt_max    = {RW{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q, level_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  rep_state_e             state_q, state_d;
  logic [RW-1:0]          rcnt_q, rcnt_d;
  logic                   press_q, press_d;

  logic w_synced;
  logic w_to_press;
  logic w_to_release;

  assign w_synced = sync_q[SYNC_STAGES-1];

  // Debounce: count consecutive disagreeing cycles; accept the new level
  // on the cycle after the count reaches DEBOUNCE_CYCLES.
  always_comb begin
    level_d = level_q;
    dcnt_d  = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (w_synced != level_q) begin
      if (dcnt_q == c_dcnt_max) begin
        level_d = w_synced;
        rise_d  = w_synced;
        fall_d  = ~w_synced;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  assign w_to_press   = (level_d != level_q) && (level_d == PRESS_LEVEL);
  assign w_to_release = (level_d != level_q) && (level_d != PRESS_LEVEL);

  // Repeat FSM: press on the accepted edge, then after REPEAT_DELAY and
  // every REPEAT_PERIOD while enabled; a release always wins.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    press_d = 1'b0;
    if (w_to_press) begin
      state_d = ST_DELAY;
      rcnt_d  = '0;
      press_d = 1'b1;
    end else if (w_to_release) begin
      state_d = ST_IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        ST_DELAY, ST_REPEAT: begin
          if (!repeat_en_i) begin
            state_d = ST_DELAY;
            rcnt_d  = '0;
          end else if (rcnt_q == ((state_q == ST_DELAY) ? c_delay_last : c_period_last)) begin
            state_d = ST_REPEAT;
            rcnt_d  = '0;
            press_d = 1'b1;
          end else if (rcnt_q != c_rcnt_max) begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  // State registers; reset forces the idle, released-level view at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
      level_q <= INIT_LEVEL;
      dcnt_q  <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      state_q <= ST_IDLE;
      rcnt_q  <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      level_q <= level_d;
      dcnt_q  <= dcnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module      : button_conditioner                                         |
// | Description : Multi-channel button/switch conditioner: per channel       |
// |               sync, debounce, rise/fall pulses and hold-to-repeat press. |
// | Revision    : 1.0 - initial multi-channel release                        |
// ----------------------------------------------------------------------------
module button_conditioner
  import button_pkg::*;
#(
  parameter int   CHANNELS        = 4,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   REPEAT_DELAY    = 25000000,
  parameter int   REPEAT_PERIOD   = 5000000,
  parameter logic INIT_LEVEL      = 1'b1,
  parameter logic PRESS_LEVEL     = 1'b0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] raw_i,
  input  logic [CHANNELS-1:0] repeat_en_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic [CHANNELS-1:0] press_o
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("button_conditioner: CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1) begin : g_bad_delay
    $error("button_conditioner: REPEAT_DELAY must be >= 1");
  end
  if (REPEAT_PERIOD < 1) begin : g_bad_period
    $error("button_conditioner: REPEAT_PERIOD must be >= 1");
  end

  // Fully independent channels; no shared state between them.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    button_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .INIT_LEVEL     (INIT_LEVEL),
      .PRESS_LEVEL    (PRESS_LEVEL)
    ) u_chan (
      .clock      (clock),
      .reset_n    (reset_n),
      .raw_i      (raw_i[g]),
      .repeat_en_i(repeat_en_i[g]),
      .level_o    (level_o[g]),
      .rise_o     (rise_o[g]),
      .fall_o     (fall_o[g]),
      .press_o    (press_o[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module      : tb_button_conditioner                                      |
// | Description : Self-checking bench: directed vector table, reset corner   |
// |               case and randomized traffic against a window model.        |
// | Revision    : 1.0 - initial multi-channel release                        |
// ----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [CH-1:0] raw = '1;
  logic [CH-1:0] en = '0;
  logic [CH-1:0] level, rise, fall, press;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  button_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .INIT_LEVEL(1'b1), .PRESS_LEVEL(1'b0)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .raw_i      (raw),
    .repeat_en_i(en),
    .level_o    (level),
    .rise_o     (rise),
    .fall_o     (fall),
    .press_o    (press)
  );

  // ---------------- reference model ----------------
  // hist[k] holds raw as sampled k clock edges ago. The level flips when the
  // samples seen SS..SS+DB edges ago all disagree with it.
  logic [CH-1:0] hist [0:SS+DB];
  logic [CH-1:0] m_level, m_rise, m_fall, m_press;
  bit            m_active [CH];
  int            m_ref    [CH];
  int            m_need   [CH];
  int            edge_no = 0;

  task automatic model_reset();
    for (int k = 0; k <= SS + DB; k++) hist[k] = '1;
    m_level = '1; m_rise = '0; m_fall = '0; m_press = '0;
    for (int c = 0; c < CH; c++) begin
      m_active[c] = 1'b0; m_ref[c] = 0; m_need[c] = RD;
    end
  endtask

  task automatic model_step();
    bit flip;
    for (int k = SS + DB; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = raw;
    edge_no++;
    for (int c = 0; c < CH; c++) begin
      m_rise[c] = 1'b0; m_fall[c] = 1'b0; m_press[c] = 1'b0;
      flip = 1'b1;
      for (int k = SS; k <= SS + DB; k++)
        if (hist[k][c] == m_level[c]) flip = 1'b0;
      if (flip) begin
        m_level[c] = ~m_level[c];
        if (m_level[c]) begin
          m_rise[c]   = 1'b1;
          m_active[c] = 1'b0;
        end else begin
          m_fall[c]   = 1'b1;
          m_press[c]  = 1'b1;
          m_active[c] = 1'b1;
          m_ref[c]    = edge_no;
          m_need[c]   = RD;
        end
      end else if (m_active[c]) begin
        if (!en[c]) begin
          m_ref[c]  = edge_no;
          m_need[c] = RD;
        end else if (edge_no - m_ref[c] == m_need[c]) begin
          m_press[c] = 1'b1;
          m_ref[c]   = edge_no;
          m_need[c]  = RP;
        end
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic cmp(input string name, input logic [4*CH-1:0] got, input logic [4*CH-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {level,rise,fall,press}=%h required %h", name, got, exp);
    end
  endtask

  // One clock edge: advance the model, then compare #1 after the edge.
  task automatic tick();
    @(posedge clock);
    if (reset_n) model_step(); else model_reset();
    #1;
    cmp($sformatf("model@%0d", edge_no), {level, rise, fall, press},
        {m_level, m_rise, m_fall, m_press});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [CH-1:0] raw;
    logic [CH-1:0] en;
    logic [7:0]    n;
    logic [CH-1:0] lv;
    logic [CH-1:0] ri;
    logic [CH-1:0] fa;
    logic [CH-1:0] pr;
  } vec_t;

  vec_t vt [$];

  task automatic add(input logic [3:0] r, input logic [3:0] e, input int n,
                     input logic [3:0] lv, input logic [3:0] ri,
                     input logic [3:0] fa, input logic [3:0] pr);
    vec_t v;
    v.raw = r; v.en = e; v.n = 8'(n); v.lv = lv; v.ri = ri; v.fa = fa; v.pr = pr;
    vt.push_back(v);
  endtask

  int hold [CH];
  int j;

  initial begin
    model_reset();
    // Reset idle
    add(4'hF, 4'h0, 20, 4'hF, 4'h0, 4'h0, 4'h0);
    // Short glitch rejected
    add(4'hE, 4'h0,  3, 4'hF, 4'h0, 4'h0, 4'h0);
    add(4'hF, 4'h0, 10, 4'hF, 4'h0, 4'h0, 4'h0);
    // Held press: accepted on the 7th edge, then repeats at tp+10, +13, +16
    add(4'hE, 4'h1,  6, 4'hF, 4'h0, 4'h0, 4'h0);
    add(4'hE, 4'h1,  1, 4'hE, 4'h0, 4'h1, 4'h1);
    add(4'hE, 4'h1,  9, 4'hE, 4'h0, 4'h0, 4'h0);
    add(4'hE, 4'h1,  1, 4'hE, 4'h0, 4'h0, 4'h1);
    add(4'hE, 4'h1,  2, 4'hE, 4'h0, 4'h0, 4'h0);
    add(4'hE, 4'h1,  1, 4'hE, 4'h0, 4'h0, 4'h1);
    add(4'hE, 4'h1,  3, 4'hE, 4'h0, 4'h0, 4'h1);
    // Release at tp+17: repeat at tp+22 still fires, rise at tp+23, then quiet
    add(4'hF, 4'h1,  6, 4'hE, 4'h0, 4'h0, 4'h1);
    add(4'hF, 4'h1,  1, 4'hF, 4'h1, 4'h0, 4'h0);
    add(4'hF, 4'h1, 10, 4'hF, 4'h0, 4'h0, 4'h0);
    // Repeat disabled: single press only
    add(4'hE, 4'h0,  7, 4'hE, 4'h0, 4'h1, 4'h1);
    add(4'hE, 4'h0, 25, 4'hE, 4'h0, 4'h0, 4'h0);
    add(4'hF, 4'h0,  7, 4'hF, 4'h1, 4'h0, 4'h0);
    // All channels together, repeats aligned
    add(4'h0, 4'hF,  7, 4'h0, 4'h0, 4'hF, 4'hF);
    add(4'h0, 4'hF, 10, 4'h0, 4'h0, 4'h0, 4'hF);
    add(4'h0, 4'hF,  3, 4'h0, 4'h0, 4'h0, 4'hF);
    add(4'h0, 4'hF,  1, 4'h0, 4'h0, 4'h0, 4'h0);

    raw = '1; en = '0; reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    cmp("reset", {level, rise, fall, press}, {4'hF, 4'h0, 4'h0, 4'h0});
    reset_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      raw = vt[i].raw;
      en  = vt[i].en;
      repeat (int'(vt[i].n)) tick();
      cmp($sformatf("vec%0d", i), {level, rise, fall, press},
          {vt[i].lv, vt[i].ri, vt[i].fa, vt[i].pr});
    end

    // Asynchronous reset in the middle of REPEAT with the buttons held
    reset_n = 1'b0;
    model_reset();
    #1;
    cmp("rst_async", {level, rise, fall, press}, {4'hF, 4'h0, 4'h0, 4'h0});
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    cmp("rst_release", {level, rise, fall, press}, {4'hF, 4'h0, 4'h0, 4'h0});
    repeat (5) tick();
    cmp("rst_hold6", {level, rise, fall, press}, {4'hF, 4'h0, 4'h0, 4'h0});
    tick();
    cmp("rst_press", {level, rise, fall, press}, {4'h0, 4'h0, 4'hF, 4'hF});

    // Randomized traffic: per-channel random hold lengths, occasional enable flips
    en = '1;
    for (int c = 0; c < CH; c++) hold[c] = $urandom_range(1, 30);
    repeat (3000) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          raw[c]  = ~raw[c];
          hold[c] = $urandom_range(1, 30);
        end else begin
          hold[c]--;
        end
      end
      if ($urandom_range(0, 31) == 0) begin
        j = $urandom_range(0, CH - 1);
        en[j] = ~en[j];
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
